// File: rtl/input_line_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : input_line_buffer_pkg
// Brief    : Shared sizes, state encoding and size check for the 3x3 conv
//            input line-buffer controller.
// Revision : 1.0 - initial release
// ============================================================================
package input_line_buffer_pkg;

  localparam int MAX_IMG_SIZE    = 128;
  localparam int SIZE_WIDTH      = 8;
  localparam int BRAM_ADDR_WIDTH = 7;
  localparam int MIN_IMG_SIZE    = 3;

  // Controller state encoding
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE      = 3'd0;
  localparam state_t ST_ROW_START = 3'd1;
  localparam state_t ST_COL_RD    = 3'd2;
  localparam state_t ST_COL_SH    = 3'd3;
  localparam state_t ST_PAD_SH    = 3'd4;
  localparam state_t ST_ROW_END   = 3'd5;
  localparam state_t ST_DONE      = 3'd6;

  // True when an image side can be processed by the datapath
  function automatic logic size_ok(input logic [SIZE_WIDTH-1:0] n);
    return (n >= SIZE_WIDTH'(MIN_IMG_SIZE)) && (n <= SIZE_WIDTH'(MAX_IMG_SIZE));
  endfunction

endpackage
`default_nettype wire

// File: rtl/input_line_buffer_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : input_line_buffer_ctrl
// Brief    : Sequencer for the 3x3 conv line-buffer datapath. Walks the image
//            in row sweeps, driving window shift/reset, row-zero muxes, BRAM
//            enables and the BRAM address counter, and emits one strobe per
//            completed 3x3 window with its center coordinate.
//            Build option LINEBUFF_CTRL_PADDING_EN: defined gives zero-padded
//            "same" output (N x N windows); undefined gives "valid" output
//            ((N-2) x (N-2) windows, no right padding column, no extra sweep).
// Revision : 1.0 - initial release
// ============================================================================
module input_line_buffer_ctrl
  import input_line_buffer_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [SIZE_WIDTH-1:0] img_size,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  win_valid,
  input  logic                  win_ready,
  output logic [SIZE_WIDTH-1:0] win_row,
  output logic [SIZE_WIDTH-1:0] win_col,
  output logic                  busy,
  output logic                  done,
  output logic                  cfg_err,
  output logic                  Wr_window,
  output logic                  Shift_window,
  output logic                  Rst_window,
  output logic                  window_row_n_mux,
  output logic                  window_row_n_1_mux,
  output logic                  window_row_n_2_mux,
  output logic                  ena_linebuff_BRAM,
  output logic                  wea_linebuff_BRAM,
  output logic                  enb_linebuff_BRAM,
  output logic                  en_linebuff_BRAM_counter,
  output logic                  rst_linebuff_BRAM_counter
);

  state_t                state;
  logic [SIZE_WIDTH-1:0] n;          // latched image side
  logic [SIZE_WIDTH-1:0] r;          // sweep index
  logic [SIZE_WIDTH-1:0] c;          // column / shift index within a sweep
  logic [SIZE_WIDTH-1:0] c_next;
  logic [SIZE_WIDTH-1:0] last_row;
  logic [SIZE_WIDTH-1:0] win_row_q;
  logic [SIZE_WIDTH-1:0] win_col_q;
  logic                  pending;
  logic                  cfg_err_q;
  logic                  can_emit;
  logic                  fire;
  logic                  fire_col;
  logic                  emits_window;
  logic                  rows_live;

`ifdef LINEBUFF_CTRL_PADDING_EN
  // Extra bottom sweep (r = N) feeds the zero row under the last image row
  assign last_row     = n;
  assign emits_window = (r != '0) && (c != '0);
`else
  assign last_row     = n - SIZE_WIDTH'(1);
  assign emits_window = (r >= SIZE_WIDTH'(2)) && (c >= SIZE_WIDTH'(2));
`endif

  // A shift may only land once the previous window has been taken
  assign can_emit = !pending || win_ready;
  assign c_next   = c + SIZE_WIDTH'(1);

  // Decide whether the shift state completes its shift this cycle
  always_comb begin
    fire = 1'b0;
    case (state)
      ST_COL_SH: fire = ((r == n) || in_valid) && can_emit;
      ST_PAD_SH: fire = can_emit;
      default:   fire = 1'b0;
    endcase
  end

  assign fire_col = fire && (state == ST_COL_SH);

  // Control strobes; during reset only the window/counter resets are held
  assign Rst_window                = !reset_n || (state == ST_ROW_START);
  assign rst_linebuff_BRAM_counter = !reset_n || (state == ST_ROW_START);
  assign Wr_window                 = reset_n && fire;
  assign Shift_window              = reset_n && fire;
  assign en_linebuff_BRAM_counter  = reset_n && fire_col;
  assign in_ready                  = reset_n && fire_col && (r < n);
  assign ena_linebuff_BRAM         = in_ready;
  assign wea_linebuff_BRAM         = in_ready;
  assign enb_linebuff_BRAM         = reset_n && (state == ST_COL_RD);

  // Row muxes follow the sweep index except in the right padding column
  assign rows_live = reset_n && ((state == ST_ROW_START) || (state == ST_COL_RD) ||
                                 (state == ST_COL_SH)    || (state == ST_ROW_END));
  assign window_row_n_mux   = rows_live && (r < n);
  assign window_row_n_1_mux = rows_live && (r >= SIZE_WIDTH'(1));
  assign window_row_n_2_mux = rows_live && (r >= SIZE_WIDTH'(2));

  assign busy      = reset_n && (state != ST_IDLE);
  assign done      = reset_n && (state == ST_DONE);
  assign cfg_err   = reset_n && cfg_err_q;
  assign win_valid = reset_n && pending;
  assign win_row   = reset_n ? win_row_q : '0;
  assign win_col   = reset_n ? win_col_q : '0;

  // Sweep sequencing, window-pending tracking and configuration checking
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      n         <= '0;
      r         <= '0;
      c         <= '0;
      pending   <= 1'b0;
      win_row_q <= '0;
      win_col_q <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      cfg_err_q <= 1'b0;
      if (pending && win_ready) begin
        pending <= 1'b0;
      end
      // A new window overrides the clear of the one just handed off
      if (fire && emits_window) begin
        pending   <= 1'b1;
        win_row_q <= r - SIZE_WIDTH'(1);
        win_col_q <= c - SIZE_WIDTH'(1);
      end
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (size_ok(img_size)) begin
              n     <= img_size;
              r     <= '0;
              state <= ST_ROW_START;
            end else begin
              cfg_err_q <= 1'b1;
            end
          end
        end
        ST_ROW_START: begin
          c     <= '0;
          state <= ST_COL_RD;
        end
        ST_COL_RD: begin
          state <= ST_COL_SH;
        end
        ST_COL_SH: begin
          if (fire) begin
            c <= c_next;
            if (c_next == n) begin
`ifdef LINEBUFF_CTRL_PADDING_EN
              state <= ST_PAD_SH;
`else
              state <= ST_ROW_END;
`endif
            end else begin
              state <= ST_COL_RD;
            end
          end
        end
        ST_PAD_SH: begin
          if (fire) begin
            state <= ST_ROW_END;
          end
        end
        ST_ROW_END: begin
          if (can_emit) begin
            if (r == last_row) begin
              state <= ST_DONE;
            end else begin
              r     <= r + SIZE_WIDTH'(1);
              state <= ST_ROW_START;
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
